// File: rtl/dual_port_mem_responder.sv
// Shared single-ported word memory serving CPU port A (instr) and B (data).
// Ports: clk, reset (sync, active-high); per port x in {a,b}:
//   read_x_i, write_x_i, wmask_x_i[3:0], address_x_i[31:0], wdata_x_i[31:0]
//   -> resp_x_o (1-cycle pulse), rdata_x_o[31:0] (held between responses).
// Build option: MEM_RANDOM_LATENCY_EN adds 0..3 LFSR-chosen cycles per access.
module dual_port_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a_i,
  input  logic        write_a_i,
  input  logic [3:0]  wmask_a_i,
  input  logic [31:0] address_a_i,
  input  logic [31:0] wdata_a_i,
  output logic        resp_a_o,
  output logic [31:0] rdata_a_o,
  input  logic        read_b_i,
  input  logic        write_b_i,
  input  logic [3:0]  wmask_b_i,
  input  logic [31:0] address_b_i,
  input  logic [31:0] wdata_b_i,
  output logic        resp_b_o,
  output logic [31:0] rdata_b_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [4:0] LAT5 = 5'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t               state_q;
  logic [4:0]           cnt_q;
  logic                 port_q;
  logic                 wr_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [3:0]           wmask_q;
  logic [31:0]          wdata_q;
  logic                 resp_a_q;
  logic                 resp_b_q;
  logic [31:0]          rdata_a_q;
  logic [31:0]          rdata_b_q;

  logic [31:0] mem_q [DEPTH];

  logic                 req_d;
  logic                 port_d;
  logic                 wr_d;
  logic [ADDR_BITS-1:0] idx_d;
  logic [3:0]           wmask_d;
  logic [31:0]          wdata_d;
  logic [4:0]           lat_d;
  logic                 mem_we;

  logic unused_addr;
  assign unused_addr = ^{address_a_i[31:ADDR_BITS+2],
                         address_a_i[1:0],
                         address_b_i[31:ADDR_BITS+2],
                         address_b_i[1:0]};

`ifdef MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // x^8+x^6+x^5+x^4+1, stepped once per grant
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else if (state_q == IDLE && req_d) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  assign lat_d = LAT5 + {3'b000, lfsr_q[1:0]};
`else
  assign lat_d = LAT5;
`endif

  // B wins whenever it has anything pending; read+write counts as write
  always_comb begin
    port_d  = read_b_i | write_b_i;
    req_d   = port_d | read_a_i | write_a_i;
    wr_d    = port_d ? write_b_i : write_a_i;
    idx_d   = port_d ? address_b_i[ADDR_BITS+1:2]
                     : address_a_i[ADDR_BITS+1:2];
    wmask_d = port_d ? wmask_b_i : wmask_a_i;
    wdata_d = port_d ? wdata_b_i : wdata_a_i;
  end

  // The access itself happens on the edge that leaves RESP, which is
  // also the edge that raises resp; reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      resp_a_q  <= 1'b0;
      resp_b_q  <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      resp_a_q <= 1'b0;
      resp_b_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_d) begin
            port_q  <= port_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            cnt_q   <= lat_d - 5'd1;
            state_q <= (lat_d == 5'd1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          if (port_q) begin
            resp_b_q <= 1'b1;
            if (!wr_q) rdata_b_q <= mem_q[idx_q];
          end else begin
            resp_a_q <= 1'b1;
            if (!wr_q) rdata_a_q <= mem_q[idx_q];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we = !reset && state_q == RESP && wr_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign resp_a_o  = resp_a_q;
  assign resp_b_o  = resp_b_q;
  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule
